// File: rtl/keypad_scanner_fifo.sv
// Keypad matrix scanner with press/release debounce and a show-ahead key-code FIFO.
//
// Drives one column low at a time, synchronises the active-low row lines, debounces the
// first key found in a column, and queues its code (row * COLS + col) for a downstream
// reader. No auto-repeat: a held key yields one code until it has been cleanly released.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   RST        synchronous reset, active-high
//   RowIn      asynchronous row lines, active-low
//   ColOut     one-cold column drive
//   KeyRdy     FIFO non-empty
//   KeyRd      pop request, ignored while empty
//   KeyCode    FIFO head, valid while KeyRdy = 1
//   FifoCount  number of queued codes
//   Overflow   sticky, a debounced key was dropped because the FIFO was full
//   ClearOvf   clears Overflow (an overflow on the same edge wins)
module keypad_scanner_fifo #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CW              = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                                clk,
  input  logic                                RST,
  input  logic [ROWS-1:0]                     RowIn,
  output logic [COLS-1:0]                     ColOut,
  output logic                                KeyRdy,
  input  logic                                KeyRd,
  output logic [CW-1:0]                       KeyCode,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     FifoCount,
  output logic                                Overflow,
  input  logic                                ClearOvf
);

  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COLW = $clog2(COLS);
  localparam int unsigned DWW  = $clog2(SCAN_DIV);
  localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] StScan     = 2'd0;
  localparam logic [1:0] StDebounce = 2'd1;
  localparam logic [1:0] StHeld     = 2'd2;
  localparam logic [1:0] StRelease  = 2'd3;

  logic [ROWS-1:0] rs_meta_q, rs_q;
  logic [1:0]      state_q, state_d;
  logic [COLW-1:0] col_q, col_d, col_next;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d, low_row;
  logic            row_low, push;
  logic [CW-1:0]   code;

  logic [CW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [FCW-1:0]  count_q;
  logic            ovf_q;
  logic            full, empty, pop, wr, ovf_set;

  // Lowest-index low row wins when several rows are low in the sampled column.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs_q[i]) low_row = RW'(i);
    end
  end

  assign row_low  = ~rs_q[row_q];
  assign col_next = (col_q == COLW'(COLS - 1)) ? '0 : col_q + 1'b1;
  assign code     = CW'(row_q) * CW'(COLS) + CW'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    push    = 1'b0;
    case (state_q)
      StScan: begin
        if (dwell_q == DWW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (!(&rs_q)) begin
            row_d   = low_row;
            cnt_d   = DBW'(1);
            state_d = StDebounce;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (row_low) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            push    = 1'b1;
            state_d = StHeld;
          end
        end else begin
          // Bounce before acceptance: drop the key and move on with the scan.
          col_d   = col_next;
          dwell_d = '0;
          state_d = StScan;
        end
      end
      StHeld: begin
        if (!row_low) begin
          cnt_d   = DBW'(1);
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!row_low) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            col_d   = col_next;
            dwell_d = '0;
            state_d = StScan;
          end
        end else begin
          state_d = StHeld;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rs_meta_q <= '1;
      rs_q      <= '1;
      state_q   <= StScan;
      col_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
    end else begin
      rs_meta_q <= RowIn;
      rs_q      <= rs_meta_q;
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
    end
  end

  // FIFO: a full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign full    = (count_q == FCW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = KeyRd & ~empty;
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q] <= code;
        wptr_q        <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_set | (ovf_q & ~ClearOvf);
    end
  end

  always_comb begin
    ColOut        = '1;
    ColOut[col_q] = 1'b0;
  end

  assign KeyRdy    = ~empty;
  assign KeyCode   = mem_q[rptr_q];
  assign FifoCount = count_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Bench for keypad_scanner_fifo: a physical keypad model drives RowIn from the pressed-key
// matrix and ColOut; expected codes go into a scoreboard queue at press time and are popped
// when the DUT presents them.
module tb_keypad_scanner_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RST, KeyRd, ClearOvf;
  logic [3:0] RowIn, ColOut, KeyCode;
  logic [2:0] FifoCount;
  logic       KeyRdy, Overflow;

  logic       KeyRd2, ClearOvf2;
  logic [1:0] RowIn2;
  logic [2:0] ColOut2, KeyCode2, FifoCount2;
  logic       KeyRdy2, Overflow2;

  logic [3:0][3:0] pressed;
  logic [1:0][2:0] pressed2;

  int checks = 0;
  int failures = 0;
  logic [3:0] sb[$];
  logic [2:0] sb2[$];

  keypad_scanner_fifo dut (
    .clk(clk), .RST(RST), .RowIn(RowIn), .ColOut(ColOut), .KeyRdy(KeyRdy), .KeyRd(KeyRd),
    .KeyCode(KeyCode), .FifoCount(FifoCount), .Overflow(Overflow), .ClearOvf(ClearOvf)
  );

  keypad_scanner_fifo #(.ROWS(2), .COLS(3), .SCAN_DIV(3), .DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .RST(RST), .RowIn(RowIn2), .ColOut(ColOut2), .KeyRdy(KeyRdy2), .KeyRd(KeyRd2),
    .KeyCode(KeyCode2), .FifoCount(FifoCount2), .Overflow(Overflow2), .ClearOvf(ClearOvf2)
  );

  // A pressed switch shorts its row to its column while that column is driven low.
  always_comb begin
    RowIn = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !ColOut[c]) RowIn[r] = 1'b0;
  end

  always_comb begin
    RowIn2 = '1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        if (pressed2[r][c] && !ColOut2[c]) RowIn2[r] = 1'b0;
  end

  // Returns at the first negedge on which column c is driven after another column was.
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] want;
    bit seen_other;
    want = ~(4'b0001 << c);
    seen_other = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!seen_other) seen_other = (ColOut !== want);
      else if (ColOut === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic hold_key(input int r, input int c, input int hold, input int gap);
    pressed[r][c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[r][c] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_pop(output logic rdy, output logic [3:0] code);
    @(negedge clk);
    rdy = KeyRdy;
    code = KeyCode;
    KeyRd = 1'b1;
    @(negedge clk);
    KeyRd = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; KeyRd = 1'b0; ClearOvf = 1'b0; KeyRd2 = 1'b0; ClearOvf2 = 1'b0;
    pressed = '0; pressed2 = '0;
    repeat (3) @(negedge clk);
    checks++; if (ColOut !== 4'b1110) begin failures++; $display("FAIL reset_colout got %b want 1110", ColOut); end
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL reset_keyrdy got %b want 0", KeyRdy); end
    checks++; if (KeyCode !== 4'd0) begin failures++; $display("FAIL reset_keycode got %0d want 0", KeyCode); end
    checks++; if (FifoCount !== 3'd0) begin failures++; $display("FAIL reset_count got %0d want 0", FifoCount); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", Overflow); end
    checks++; if (ColOut2 !== 3'b110) begin failures++; $display("FAIL reset_colout2 got %b want 110", ColOut2); end
    RST = 1'b0;
  endtask

  task automatic test_basic_press;
    bit ok;
    logic rdy;
    logic [3:0] code, exp_col, want;
    wait_col(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_wait_col got timeout want col0"); end
    pressed[0][0] = 1'b1;
    sb.push_back(4'd0);
    // Sample edge is the 4th edge of the column; the push lands 3 edges later.
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL basic_early_rdy got %b want 0", KeyRdy); end
    @(negedge clk);
    checks++; if (KeyRdy !== 1'b1) begin failures++; $display("FAIL basic_rdy got %b want 1", KeyRdy); end
    checks++; if (KeyCode !== sb[0]) begin failures++; $display("FAIL basic_code got %0d want %0d", KeyCode, sb[0]); end
    checks++; if (FifoCount !== 3'd1) begin failures++; $display("FAIL basic_count got %0d want 1", FifoCount); end
    repeat (6) @(negedge clk);
    pressed[0][0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ColOut !== 4'b1110) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL basic_resume got stuck %b want scan", ColOut); end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = ~(4'b0001 << ((1 + i / 4) % 4));
      checks++; if (ColOut !== exp_col) begin failures++; $display("FAIL scan_seq[%0d] got %b want %b", i, ColOut, exp_col); end
    end
    do_pop(rdy, code);
    want = sb.pop_front();
    checks++; if (rdy !== 1'b1 || code !== want) begin failures++; $display("FAIL basic_pop got rdy=%b code=%0d want rdy=1 code=%0d", rdy, code, want); end
    checks++; if (FifoCount !== 3'd0) begin failures++; $display("FAIL basic_drain got %0d want 0", FifoCount); end
  endtask

  task automatic test_row2_col3;
    logic rdy;
    logic [3:0] code, want;
    sb.push_back(4'd11);
    hold_key(2, 3, 40, 30);
    do_pop(rdy, code);
    want = sb.pop_front();
    checks++; if (rdy !== 1'b1 || code !== want) begin failures++; $display("FAIL r2c3_code got rdy=%b code=%0d want rdy=1 code=%0d", rdy, code, want); end
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL r2c3_rdy_after_pop got %b want 0", KeyRdy); end
    checks++; if (FifoCount !== 3'd0) begin failures++; $display("FAIL r2c3_count_after_pop got %0d want 0", FifoCount); end
  endtask

  task automatic test_glitch;
    bit ok;
    wait_col(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL glitch_wait_col got timeout want col1"); end
    pressed[0][1] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pressed[0][1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ColOut !== 4'b1011) begin failures++; $display("FAIL glitch_next_col got %b want 1011", ColOut); end
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL glitch_rdy got %b want 0", KeyRdy); end
    repeat (40) @(negedge clk);
    checks++; if (FifoCount !== 3'd0) begin failures++; $display("FAIL glitch_count got %0d want 0", FifoCount); end
  endtask

  task automatic test_release_bounce;
    logic rdy;
    logic [3:0] code, want;
    sb.push_back(4'd4);
    pressed[1][0] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[1][0] = 1'b0;
    repeat (2) @(negedge clk);
    pressed[1][0] = 1'b1;
    @(negedge clk);
    pressed[1][0] = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (FifoCount !== 3'd1) begin failures++; $display("FAIL bounce_count got %0d want 1", FifoCount); end
    do_pop(rdy, code);
    want = sb.pop_front();
    checks++; if (rdy !== 1'b1 || code !== want) begin failures++; $display("FAIL bounce_code got rdy=%b code=%0d want rdy=1 code=%0d", rdy, code, want); end
  endtask

  task automatic test_overflow;
    logic rdy;
    logic [3:0] code, want;
    int rows[5] = '{0, 1, 2, 3, 1};
    int cols[5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) sb.push_back(4'(rows[k] * 4 + cols[k]));
      hold_key(rows[k], cols[k], 40, 30);
    end
    checks++; if (FifoCount !== 3'd4) begin failures++; $display("FAIL ovf_count got %0d want 4", FifoCount); end
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", Overflow); end
    for (int k = 0; k < 4; k++) begin
      do_pop(rdy, code);
      want = sb.pop_front();
      checks++; if (rdy !== 1'b1 || code !== want) begin failures++; $display("FAIL ovf_pop[%0d] got rdy=%b code=%0d want rdy=1 code=%0d", k, rdy, code, want); end
    end
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL ovf_empty got %b want 0", KeyRdy); end
    ClearOvf = 1'b1;
    @(negedge clk);
    ClearOvf = 1'b0;
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", Overflow); end
  endtask

  task automatic test_full_push_pop;
    bit ok;
    logic rdy;
    logic [3:0] code, want;
    int rows[4] = '{0, 1, 2, 3};
    int cols[4] = '{3, 1, 2, 1};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(4'(rows[k] * 4 + cols[k]));
      hold_key(rows[k], cols[k], 40, 30);
    end
    wait_col(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fullpp_wait_col got timeout want col0"); end
    pressed[3][0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    want = sb.pop_front();
    checks++; if (KeyCode !== want) begin failures++; $display("FAIL fullpp_head got %0d want %0d", KeyCode, want); end
    KeyRd = 1'b1;
    sb.push_back(4'd12);
    @(negedge clk);
    KeyRd = 1'b0;
    checks++; if (FifoCount !== 3'd4) begin failures++; $display("FAIL fullpp_count got %0d want 4", FifoCount); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL fullpp_ovf got %b want 0", Overflow); end
    repeat (4) @(negedge clk);
    pressed[3][0] = 1'b0;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      do_pop(rdy, code);
      want = sb.pop_front();
      checks++; if (rdy !== 1'b1 || code !== want) begin failures++; $display("FAIL fullpp_pop[%0d] got rdy=%b code=%0d want rdy=1 code=%0d", k, rdy, code, want); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    hold_key(0, 2, 40, 30);
    hold_key(3, 3, 40, 30);
    sb.push_back(4'd2);
    sb.push_back(4'd15);
    checks++; if (FifoCount !== 3'd2) begin failures++; $display("FAIL rstmid_pre_count got %0d want 2", FifoCount); end
    wait_col(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_wait_col got timeout want col1"); end
    pressed[2][1] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    pressed[2][1] = 1'b0;
    @(negedge clk);
    sb.delete();
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL rstmid_rdy got %b want 0", KeyRdy); end
    checks++; if (FifoCount !== 3'd0) begin failures++; $display("FAIL rstmid_count got %0d want 0", FifoCount); end
    checks++; if (ColOut !== 4'b1110) begin failures++; $display("FAIL rstmid_colout got %b want 1110", ColOut); end
    RST = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (KeyRdy !== 1'b0) begin failures++; $display("FAIL rstmid_no_push got %b want 0", KeyRdy); end
  endtask

  task automatic test_sweep;
    logic [2:0] want;
    sb2.push_back(3'd5);
    pressed2[1][2] = 1'b1;
    repeat (30) @(negedge clk);
    pressed2[1][2] = 1'b0;
    repeat (20) @(negedge clk);
    want = sb2.pop_front();
    checks++; if (KeyRdy2 !== 1'b1 || KeyCode2 !== want) begin failures++; $display("FAIL sweep_code got rdy=%b code=%0d want rdy=1 code=%0d", KeyRdy2, KeyCode2, want); end
    KeyRd2 = 1'b1;
    @(negedge clk);
    KeyRd2 = 1'b0;
    sb2.push_back(3'd1);
    pressed2[0][1] = 1'b1;
    pressed2[1][1] = 1'b1;
    repeat (30) @(negedge clk);
    pressed2 = '0;
    repeat (20) @(negedge clk);
    checks++; if (FifoCount2 !== 3'd1) begin failures++; $display("FAIL sweep_multi_count got %0d want 1", FifoCount2); end
    want = sb2.pop_front();
    checks++; if (KeyCode2 !== want) begin failures++; $display("FAIL sweep_multi_code got %0d want %0d", KeyCode2, want); end
    KeyRd2 = 1'b1;
    @(negedge clk);
    KeyRd2 = 1'b0;
    checks++; if (KeyRdy2 !== 1'b0) begin failures++; $display("FAIL sweep_empty got %b want 0", KeyRdy2); end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_row2_col3();
    test_glitch();
    test_release_bounce();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
